stopwatch_core: RTL and testbench
=================================

Name: stopwatch_core

Overview:
- Upstream time-keeping stage of the stopwatch display path.
- Counts elapsed time in BCD as HH:MM:SS.cc, with centisecond resolution, from a parameterised prescaler.
- Presents the count as an 8-digit packed BCD word to the digit-multiplexing display stage.
- Provides start/stop, clear and lap-freeze control driven by single-cycle, already-debounced button pulses.

Parameters:
- TICK_DIV, 1000000, clk cycles per centisecond tick (100 MHz -> 100 Hz); minimum 2.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- start_stop  input  1  single-cycle pulse; toggles run/pause
- clear  input  1  single-cycle pulse; zeroes count when not running
- lap  input  1  single-cycle pulse; toggles display freeze
- tmp  output  32  packed BCD {h1,h0,m1,m0,s1,s0,c1,c0}; [31:28]=h1 ... [3:0]=c0
- running  output  1  high in RUN state
- lap_active  output  1  high while displayed value is frozen
- overflow  output  1  one-cycle pulse on wrap 99:59:59.99 -> 00:00:00.00

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, count=0, prescaler=0, lap register=0.
  - tmp=32'h0, running=0, lap_active=0, overflow=0.
- Reset mid-count returns to the same reset values immediately; no pulse is remembered.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE --start_stop--> RUN.
  - RUN --start_stop--> PAUSE.
  - PAUSE --start_stop--> RUN.
  - IDLE/PAUSE --clear--> IDLE.
  - clear in RUN is ignored.
- Priority when pulses coincide: clear > start_stop > lap.
  - A cycle with clear honoured ignores start_stop and lap.
  - In RUN, clear is not honoured, so start_stop and lap in the same cycle both act.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN.
  - Holds its value in PAUSE.
  - Zeroed by clear and reset.
  - Tick = (state==RUN) && (prescaler==TICK_DIV-1); prescaler wraps to 0 on that same edge.
- First tick after IDLE->RUN: occurs TICK_DIV cycles after the start_stop edge.
- Count update:
  - On the edge where tick is asserted, increment the BCD chain with ripple carry.
  - Digit ranges: c0 0-9, c1 0-9, s0 0-9, s1 0-5, m0 0-9, m1 0-5, h0 0-9, h1 0-9.
  - A digit at its maximum with carry-in returns to 0 and carries out.
- Full wrap:
  - 99:59:59.99 + tick -> all zeros.
  - overflow=1 for exactly the following cycle.
  - Counting continues.
- Stop with a tick pending: a start_stop pulse on the tick cycle in RUN still applies that tick, then enters PAUSE.
- Output tmp (registered):
  - lap_active=0: tmp equals the live count; it reflects a tick on the same edge that updates the count.
  - lap_active=1: tmp holds the lap register while the live count keeps advancing.
- Lap:
  - lap in RUN with lap_active=0: capture the post-edge live count (including any simultaneous tick) into the lap register; lap_active=1.
  - lap while lap_active=1, in RUN or PAUSE: lap_active=0; tmp shows the live count next edge.
  - lap in IDLE, or in PAUSE with lap_active=0: ignored.
- clear when honoured: lap_active=0, and tmp becomes 0 on the same edge.
- running = (state==RUN), registered with state.
- Invalid BCD cannot arise: all digit registers are only loaded with 0 or incremented within range.

Test Plan (TICK_DIV=4):
- Run from reset:
  - Stimulus: rst pulse, then start_stop; hold 400 cycles.
  - Required: tmp=32'h0000_0100 (01.00 s); running=1; first change to 32'h0000_0001 exactly 4 cycles after the start_stop edge.
- Pause/resume:
  - Stimulus: start, run 10 cycles, start_stop, wait 50 cycles, start_stop, run 6 more.
  - Required: tmp frozen at 32'h0000_0002 during pause; reaches 32'h0000_0004 after resume (prescaler held at 2 across the pause).
- Rollover chain:
  - Stimulus: preload (via run) to 00:00:59.99, one tick -> 00:01:00.00 = 32'h0001_0000.
  - Stimulus: force count to 99:59:59.99, one tick.
  - Required: tmp=32'h0; overflow high for 1 cycle; still running.
- Lap freeze:
  - Stimulus: in RUN at 32'h0000_0003, pulse lap; run 20 cycles; pulse lap again.
  - Required: tmp=32'h0000_0003 throughout the freeze; after release tmp=32'h0000_0008.
- Clear rules:
  - Stimulus: clear in RUN.
  - Required: ignored; count continues.
  - Stimulus: pause, then clear with start_stop in the same cycle.
  - Required: IDLE, tmp=0, running=0, lap_active=0.
- Async reset mid-run:
  - Stimulus: assert rst between clk edges while in RUN with lap_active=1.
  - Required: all outputs zero immediately, before the next clk edge.

Source files
------------

// File: rtl/stopwatch_core_if.sv
// Control pulses in, packed BCD time and status out, between the stopwatch
// core and whatever drives its buttons and display.
interface stopwatch_core_if;
    logic        start_stop;
    logic        clear;
    logic        lap;
    logic [31:0] tmp;
    logic        running;
    logic        lap_active;
    logic        overflow;

    modport master (
        output start_stop, clear, lap,
        input  tmp, running, lap_active, overflow
    );

    modport slave (
        input  start_stop, clear, lap,
        output tmp, running, lap_active, overflow
    );
endinterface

// File: rtl/stopwatch_core.sv
// BCD stopwatch HH:MM:SS.cc with run/pause, clear and lap-freeze control.
//
// state   | meaning
// --------+--------------------------------------------------------
// S_IDLE  | count zeroed, waiting for start_stop
// S_RUN   | prescaler counting, count advances on each tick
// S_PAUSE | count and prescaler held; start_stop resumes, clear zeroes
module stopwatch_core #(
    parameter int TICK_DIV = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    stopwatch_core_if.slave   sw
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    // Per-digit maximum, laid out exactly like the count word
    localparam logic [31:0] DIGIT_MAX = 32'h9959_5999;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

    state_t          r_state, w_state_next;
    logic [PW-1:0]   r_presc, w_presc_next;
    logic [31:0]     r_count, w_count_next, w_count_inc;
    logic [31:0]     r_lap;
    logic [31:0]     r_tmp, w_tmp_next;
    logic            r_lap_active, w_lap_active_next;
    logic            r_overflow;
    logic            w_wrap;
    logic            w_clear_ok;
    logic            w_tick;
    logic            w_lap_ok;
    logic            w_capture;

    assign w_clear_ok = sw.clear && (r_state != S_RUN);
    assign w_tick     = (r_state == S_RUN) && (r_presc == PRESC_MAX);
    assign w_lap_ok   = sw.lap && !w_clear_ok;
    assign w_capture  = w_lap_ok && !r_lap_active && (r_state == S_RUN);

    always_comb begin : p_bcd_inc
        logic c;
        c = 1'b1;
        w_count_inc = r_count;
        for (int i = 0; i < 8; i++) begin
            if (c) begin
                if (r_count[4*i +: 4] == DIGIT_MAX[4*i +: 4]) begin
                    w_count_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_count_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        w_wrap = c;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (!w_clear_ok && sw.start_stop) w_state_next = S_RUN;
            S_RUN:   if (sw.start_stop) w_state_next = S_PAUSE;
            S_PAUSE: begin
                if (w_clear_ok)         w_state_next = S_IDLE;
                else if (sw.start_stop) w_state_next = S_RUN;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_presc_next      = r_presc;
        w_count_next      = r_count;
        w_lap_active_next = r_lap_active;
        if (w_clear_ok) begin
            w_presc_next      = '0;
            w_count_next      = '0;
            w_lap_active_next = 1'b0;
        end else begin
            if (r_state == S_RUN)
                w_presc_next = w_tick ? '0 : r_presc + 1'b1;
            if (w_tick)
                w_count_next = w_count_inc;
            if (w_lap_ok && r_lap_active)
                w_lap_active_next = 1'b0;
            else if (w_capture)
                w_lap_active_next = 1'b1;
        end
        // A fresh capture shows the same post-edge count it stores
        w_tmp_next = (w_lap_active_next && !w_capture) ? r_lap : w_count_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_presc      <= '0;
            r_count      <= '0;
            r_lap        <= '0;
            r_tmp        <= '0;
            r_lap_active <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_presc      <= w_presc_next;
            r_count      <= w_count_next;
            r_tmp        <= w_tmp_next;
            r_lap_active <= w_lap_active_next;
            r_overflow   <= w_tick && w_wrap;
            if (w_capture)
                r_lap <= w_count_next;
        end
    end

    assign sw.tmp        = r_tmp;
    assign sw.running    = (r_state == S_RUN);
    assign sw.lap_active = r_lap_active;
    assign sw.overflow   = r_overflow;
endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core: directed scenarios plus random
// button pulses, compared every cycle against a centisecond-integer model.
module tb_stopwatch_core;
    localparam int TD    = 4;
    localparam int TOTAL = 100 * 60 * 60 * 100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stopwatch_core_if sw();
    stopwatch_core #(.TICK_DIV(TD)) dut (.clk(clk), .rst(rst), .sw(sw));

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: elapsed time kept as plain centiseconds
    bit          m_run, m_pause, m_lapact, m_ovf;
    int          m_cs, m_presc;
    logic [31:0] m_lap, m_tmp;

    function automatic logic [31:0] to_bcd(int cs);
        int c, s, m, h;
        c = cs % 100;
        s = (cs / 100) % 60;
        m = (cs / 6000) % 60;
        h = cs / 360000;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
                4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_run = 0; m_pause = 0; m_lapact = 0; m_ovf = 0;
        m_cs = 0; m_presc = 0; m_lap = '0; m_tmp = '0;
    endtask

    task automatic model_step(bit ss, bit clr, bit lp);
        bit tick;
        if (clr && !m_run) begin
            m_run = 0; m_pause = 0; m_cs = 0; m_presc = 0;
            m_lapact = 0; m_ovf = 0; m_tmp = '0;
            return;
        end
        tick  = m_run && (m_presc == TD - 1);
        m_ovf = 0;
        if (m_run) m_presc = tick ? 0 : m_presc + 1;
        if (tick) begin
            m_cs  = (m_cs + 1) % TOTAL;
            m_ovf = (m_cs == 0);
        end
        if (lp) begin
            if (m_lapact) m_lapact = 0;
            else if (m_run) begin
                m_lap    = to_bcd(m_cs);
                m_lapact = 1;
            end
        end
        if (ss) begin
            if (m_run) begin m_run = 0; m_pause = 1; end
            else       begin m_run = 1; m_pause = 0; end
        end
        m_tmp = m_lapact ? m_lap : to_bcd(m_cs);
    endtask

    task automatic chk_all();
        chk("tmp",        sw.tmp,               m_tmp);
        chk("running",    32'(sw.running),      32'(m_run));
        chk("lap_active", 32'(sw.lap_active),   32'(m_lapact));
        chk("overflow",   32'(sw.overflow),     32'(m_ovf));
    endtask

    task automatic cycle(bit ss, bit clr, bit lp);
        sw.start_stop = ss;
        sw.clear      = clr;
        sw.lap        = lp;
        @(posedge clk);
        model_step(ss, clr, lp);
        @(negedge clk);
        sw.start_stop = 1'b0;
        sw.clear      = 1'b0;
        sw.lap        = 1'b0;
        chk_all();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_tmp",   sw.tmp,             32'h0);
        chk("rst_run",   32'(sw.running),    32'h0);
        chk("rst_lap",   32'(sw.lap_active), 32'h0);
        chk("rst_ovf",   32'(sw.overflow),   32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        sw.start_stop = 1'b0;
        sw.clear      = 1'b0;
        sw.lap        = 1'b0;
        model_reset();
        #2;

        // Run from reset: first tick 4 cycles after start, 100 ticks by 400
        do_reset();
        cycle(1, 0, 0);
        idle(3);
        chk("first_tick_early", sw.tmp, 32'h0000_0000);
        idle(1);
        chk("first_tick", sw.tmp, 32'h0000_0001);
        idle(396);
        chk("run_1s", sw.tmp, 32'h0000_0100);
        chk("run_1s_running", 32'(sw.running), 32'h1);

        // Pause/resume with prescaler held mid-count
        do_reset();
        cycle(1, 0, 0);
        idle(9);
        cycle(1, 0, 0);
        chk("pause_tmp", sw.tmp, 32'h0000_0002);
        idle(50);
        chk("pause_hold", sw.tmp, 32'h0000_0002);
        chk("pause_running", 32'(sw.running), 32'h0);
        cycle(1, 0, 0);
        idle(6);
        chk("resume_tmp", sw.tmp, 32'h0000_0004);

        // Rollover 59.99 s -> 1 min, then full wrap from 99:59:59.99
        do_reset();
        cycle(1, 0, 0);
        idle(23996);
        chk("pre_minute", sw.tmp, 32'h0000_5999);
        idle(4);
        chk("minute_carry", sw.tmp, 32'h0001_0000);
        idle(3);
        force dut.r_count = 32'h9959_5999;
        #1;
        release dut.r_count;
        m_cs = TOTAL - 1;
        cycle(0, 0, 0);
        chk("wrap_tmp", sw.tmp, 32'h0);
        chk("wrap_ovf", 32'(sw.overflow), 32'h1);
        chk("wrap_running", 32'(sw.running), 32'h1);
        idle(1);
        chk("ovf_one_cycle", 32'(sw.overflow), 32'h0);

        // Lap freeze and release
        do_reset();
        cycle(1, 0, 0);
        idle(12);
        chk("lap_pre", sw.tmp, 32'h0000_0003);
        cycle(0, 0, 1);
        idle(20);
        chk("lap_frozen", sw.tmp, 32'h0000_0003);
        chk("lap_active_on", 32'(sw.lap_active), 32'h1);
        cycle(0, 0, 1);
        chk("lap_release", sw.tmp, 32'h0000_0008);

        // Clear rules
        cycle(0, 1, 0);
        chk("clear_in_run", 32'(sw.running), 32'h1);
        cycle(0, 0, 1);
        cycle(1, 0, 0);
        cycle(1, 1, 0);
        chk("clear_tmp", sw.tmp, 32'h0);
        chk("clear_running", 32'(sw.running), 32'h0);
        chk("clear_lap", 32'(sw.lap_active), 32'h0);
        idle(8);
        chk("idle_after_clear", sw.tmp, 32'h0);

        // Async reset between edges while running with lap frozen
        cycle(1, 0, 0);
        idle(5);
        cycle(0, 0, 1);
        idle(3);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_tmp", sw.tmp, 32'h0);
        chk("async_run", 32'(sw.running), 32'h0);
        chk("async_lap", 32'(sw.lap_active), 32'h0);
        chk("async_ovf", 32'(sw.overflow), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Random pulses against the model
        for (int i = 0; i < 4000; i++) begin
            cycle($urandom_range(0, 11) == 0,
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 9) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
